// File: rtl/gear_pkg.sv
// Shared types and the saturated speed-to-band decode for the gear shift controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package gear_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DWELL = 2'd2
  } gear_state_t;

  // Band index of a speed sample: speed / step, saturated at the top gear.
  function automatic int unsigned band_of(input int unsigned spd,
                                          input int unsigned step,
                                          input int unsigned num_gears);
    int unsigned b;
    b = spd / step;
    if (b > num_gears - 1) b = num_gears - 1;
    return b;
  endfunction

endpackage

// File: rtl/gear_band_decode.sv
// Combinational decode of a speed sample into its saturated gear band.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module gear_band_decode #(
  parameter int SPEED_W   = 4,
  parameter int NUM_GEARS = 4,
  parameter int GEAR_W    = 2,
  parameter int STEP      = 5
) (
  input  logic [SPEED_W-1:0] speed,
  output logic [GEAR_W-1:0]  band
);
  import gear_pkg::*;

  assign band = GEAR_W'(band_of(32'(speed), STEP, NUM_GEARS));

endmodule

// File: rtl/gear_shift_ctrl.sv
// Speed-driven gear controller: single-step shifts via req/ack, minimum dwell between shifts.
// Latency: speed -> target 2 cycles; speed -> shift_req 2 cycles; ack -> next req >= DWELL+1 cycles.
// Backpressure: a pending shift holds shift_req until shift_ack; GEAR_HYST_EN adds downshift hysteresis.
module gear_shift_ctrl #(
  parameter int SPEED_W   = 4,
  parameter int NUM_GEARS = 4,
  parameter int GEAR_W    = 2,
  parameter int STEP      = 5,
  parameter int DWELL     = 4,
  parameter int HYST      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [SPEED_W-1:0] speed,
  input  logic               shift_ack,
  output logic [GEAR_W-1:0]  gear,
  output logic [GEAR_W-1:0]  target,
  output logic               shift_req,
  output logic               shift_up,
  output logic               busy
);
  import gear_pkg::*;

  // Wide enough that (gear+1)*STEP never overflows for legal parameters.
  localparam int CMP_W = SPEED_W + GEAR_W + 1;
  // Counter only ever holds DWELL-1 down to 0.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [GEAR_W-1:0] TOP_GEAR   = GEAR_W'(NUM_GEARS - 1);
  localparam logic [CMP_W-1:0]  STEP_C     = CMP_W'(STEP);
`ifdef GEAR_HYST_EN
  localparam logic [CMP_W-1:0]  HYST_C     = CMP_W'(HYST);
`else
  // Without hysteresis the down threshold sits exactly on the band edge.
  localparam logic [CMP_W-1:0]  HYST_C     = CMP_W'(0 * HYST);
`endif

  logic [SPEED_W-1:0] speed_q;
  logic [GEAR_W-1:0]  band;
  gear_state_t        state, state_d;
  logic [GEAR_W-1:0]  gear_d;
  logic               up_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [CMP_W-1:0]   speed_w, gear_w, up_thr, dn_base, dn_thr;
  logic               up_cond, dn_cond;

  gear_band_decode #(
    .SPEED_W   (SPEED_W),
    .NUM_GEARS (NUM_GEARS),
    .GEAR_W    (GEAR_W),
    .STEP      (STEP)
  ) u_decode (
    .speed (speed_q),
    .band  (band)
  );

  // Shift thresholds relative to the committed gear; down threshold clamps at zero.
  always_comb begin
    speed_w = CMP_W'(speed_q);
    gear_w  = CMP_W'(gear);
    up_thr  = (gear_w + CMP_W'(1)) * STEP_C;
    dn_base = gear_w * STEP_C;
    dn_thr  = (dn_base > HYST_C) ? (dn_base - HYST_C) : '0;
    up_cond = (gear < TOP_GEAR) && (speed_w >= up_thr);
    dn_cond = (gear != '0) && (speed_w < dn_thr);
  end

  // Sample speed and register its band decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= '0;
      target  <= '0;
    end else begin
      speed_q <= speed;
      target  <= band;
    end
  end

  // FSM state, committed gear, latched direction and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gear     <= '0;
      shift_up <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      gear     <= gear_d;
      shift_up <= up_d;
      cnt      <= cnt_d;
    end
  end

  // Next-state logic: start a shift from IDLE, commit on ack, count out the dwell.
  always_comb begin
    state_d = state;
    gear_d  = gear;
    up_d    = shift_up;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        // Up and down cannot both hold; up wins by construction anyway.
        if (en && (up_cond || dn_cond)) begin
          state_d = SHIFT;
          up_d    = up_cond;
        end
      end
      SHIFT: begin
        if (shift_ack) begin
          gear_d  = shift_up ? (gear + 1'b1) : (gear - 1'b1);
          state_d = gear_pkg::DWELL;
          cnt_d   = DWELL_LOAD;
        end
      end
      gear_pkg::DWELL: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_req = (state == SHIFT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl with a scoreboard of expected shifts.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench drives shift_ack to exercise held and immediate acks.
module tb_gear_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, shift_ack;
  logic [3:0] speed;
  logic [1:0] gear, target;
  logic       shift_req, shift_up, busy;

  typedef struct packed {
    logic       up;
    logic [1:0] gear;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  gear_shift_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .speed     (speed),
    .shift_ack (shift_ack),
    .gear      (gear),
    .target    (target),
    .shift_req (shift_req),
    .shift_up  (shift_up),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then pop the expected shift and check its direction.
  task automatic wait_req(input string tag);
    int n = 0;
    while (shift_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(shift_req), 1);
    check({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check({tag, "_dir"}, 32'(shift_up), 32'(cur.up));
    end
  endtask

  // Hold ack off for a while, then ack and check the committed gear.
  task automatic finish_shift(input string tag, input int delay);
    repeat (delay) begin
      tick();
      check({tag, "_req_hold"}, 32'(shift_req), 1);
      check({tag, "_dir_hold"}, 32'(shift_up), 32'(cur.up));
    end
    shift_ack = 1'b1;
    tick();
    shift_ack = 1'b0;
    check({tag, "_gear"}, 32'(gear), 32'(cur.gear));
    check({tag, "_req_drop"}, 32'(shift_req), 0);
    check({tag, "_busy_dwell"}, 32'(busy), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int   prev_gear, last_chg, reqs;
    logic prev_req, seen;

    // 1. Reset and quiet period.
    rst_n = 1'b0; en = 1'b0; speed = 4'd0; shift_ack = 1'b0;
    #12;
    check("rst_gear", 32'(gear), 0);
    check("rst_target", 32'(target), 0);
    check("rst_req", 32'(shift_req), 0);
    check("rst_up", 32'(shift_up), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_gear", 32'(gear), 0);
    check("idle_target", 32'(target), 0);
    check("idle_req", 32'(shift_req), 0);
    check("idle_busy", 32'(busy), 0);

    // 2. Single upshift with a late ack, then exact dwell length.
    en = 1'b1; speed = 4'd7;
    sb.push_back('{up: 1'b1, gear: 2'd1});
    tick();
    check("lag_target_1", 32'(target), 0);
    check("lag_req_1", 32'(shift_req), 0);
    tick();
    check("lag_target_2", 32'(target), 1);
    wait_req("up1");
    finish_shift("up1", 2);
    repeat (3) begin
      tick();
      check("up1_dwell_busy", 32'(busy), 1);
    end
    tick();
    check("up1_dwell_end", 32'(busy), 0);
    repeat (4) tick();
    check("up1_stable_req", 32'(shift_req), 0);
    check("up1_stable_gear", 32'(gear), 1);

    // 3. Saturated speed with ack tied high: walk to the top gear, one step per DWELL+2.
    rst_n = 1'b0; #3;
    speed = 4'd15; shift_ack = 1'b1; en = 1'b1;
    rst_n = 1'b1;
    sb.push_back('{up: 1'b1, gear: 2'd1});
    sb.push_back('{up: 1'b1, gear: 2'd2});
    sb.push_back('{up: 1'b1, gear: 2'd3});
    prev_gear = 0; last_chg = -1; reqs = 0; prev_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (shift_req && !prev_req) reqs++;
      prev_req = shift_req;
      if (int'(gear) != prev_gear) begin
        check("walk_sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("walk_gear", 32'(gear), 32'(cur.gear));
          check("walk_dir", 32'(shift_up), 32'(cur.up));
        end
        if (last_chg >= 0) check("walk_interval", 32'(c - last_chg), 6);
        last_chg  = c;
        prev_gear = int'(gear);
      end
    end
    check("walk_req_count", 32'(reqs), 3);
    check("walk_top_gear", 32'(gear), 3);
    check("walk_top_target", 32'(target), 3);
    check("walk_sb_drained", 32'(sb.size()), 0);

    // 4. Down to gear 2, then the band-edge downshift with/without hysteresis.
    speed = 4'd12;
    sb.push_back('{up: 1'b0, gear: 2'd2});
    wait_req("dn3");
    finish_shift("dn3", 0);
    wait_idle("dn3");
`ifdef GEAR_HYST_EN
    speed = 4'd9;
    repeat (10) tick();
    check("hyst_no_req", 32'(shift_req), 0);
    check("hyst_gear", 32'(gear), 2);
    speed = 4'd8;
`else
    speed = 4'd9;
`endif
    sb.push_back('{up: 1'b0, gear: 2'd1});
    wait_req("dn2");
    finish_shift("dn2", 1);
    wait_idle("dn2");

    // 5. en=0 blocks new shifts and stray acks are ignored; dropping en mid-SHIFT is harmless.
    en = 1'b0; speed = 4'd15; shift_ack = 1'b1; seen = 1'b0;
    repeat (10) begin
      tick();
      if (shift_req) seen = 1'b1;
    end
    shift_ack = 1'b0;
    check("en0_no_req", 32'(seen), 0);
    check("en0_gear", 32'(gear), 1);
    en = 1'b1;
    sb.push_back('{up: 1'b1, gear: 2'd2});
    wait_req("endrop");
    en = 1'b0;
    finish_shift("endrop", 2);
    wait_idle("endrop");
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (shift_req) seen = 1'b1;
    end
    check("endrop_no_req", 32'(seen), 0);
    check("endrop_gear", 32'(gear), 2);

    // 6. Asynchronous reset in the middle of an unacked SHIFT, then re-request.
    en = 1'b1;
    sb.push_back('{up: 1'b1, gear: 2'd3});
    wait_req("rstmid");
    tick();
    check("rstmid_req_before", 32'(shift_req), 1);
    #3; rst_n = 1'b0;
    #1;
    check("rstmid_gear", 32'(gear), 0);
    check("rstmid_target", 32'(target), 0);
    check("rstmid_req", 32'(shift_req), 0);
    check("rstmid_up", 32'(shift_up), 0);
    check("rstmid_busy", 32'(busy), 0);
    #2; rst_n = 1'b1;
    sb.push_back('{up: 1'b1, gear: 2'd1});
    wait_req("rerq");
    finish_shift("rerq", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
